// File: rtl/ber_snapshot.sv
// ber_snapshot: coherent snapshot of four 64-bit BER counters with delta computation and a 32-bit read port
module ber_snapshot #(
  parameter int NB_BER     = 64,
  parameter int NB_OUT     = 32,
  parameter int NB_PERIOD  = 32,
  parameter int NB_SNAPCNT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NB_BER-1:0]     i_samp_I,
  input  logic [NB_BER-1:0]     i_err_I,
  input  logic [NB_BER-1:0]     i_samp_Q,
  input  logic [NB_BER-1:0]     i_err_Q,
  input  logic                  i_snap_req,
  input  logic                  i_auto_en,
  input  logic [NB_PERIOD-1:0]  i_auto_period,
  input  logic                  i_rd_req,
  input  logic [2:0]            i_rd_sel,
  input  logic                  i_rd_high,
  output logic [NB_OUT-1:0]     o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_snap_done,
  output logic [NB_SNAPCNT-1:0] o_snap_count,
  output logic                  o_overrun
);
  typedef enum logic [1:0] {S_IDLE, S_DELTA, S_DONE} state_t;
  state_t                  r_state, w_next;
  logic [1:0]              r_k;
  logic [NB_BER-1:0]       r_abs [4];
  logic [NB_BER-1:0]       r_prev [4];
  logic [NB_BER-1:0]       r_dlt [4];
  logic [NB_PERIOD-1:0]    r_timer;
  logic                    r_pend, r_pend_high, r_rd_valid, r_overrun;
  logic [2:0]              r_pend_sel;
  logic [NB_OUT-1:0]       r_rd_data;
  logic [NB_SNAPCNT-1:0]   r_snap_count;
  logic                    w_auto_on, w_tick, w_trig, w_idle, w_rd_go, w_high;
  logic [2:0]              w_sel;
  logic [NB_BER-1:0]       w_reg, w_diff;

  assign w_auto_on = i_auto_en && (i_auto_period != '0);
  assign w_tick    = w_auto_on && (r_timer == i_auto_period - NB_PERIOD'(1));
  assign w_trig    = i_snap_req || w_tick;
  assign w_idle    = (r_state == S_IDLE);
  assign w_rd_go   = w_idle && (i_rd_req || r_pend);
  assign w_sel     = i_rd_req ? i_rd_sel : r_pend_sel;
  assign w_high    = i_rd_req ? i_rd_high : r_pend_high;
  assign w_reg     = w_sel[2] ? r_dlt[w_sel[1:0]] : r_abs[w_sel[1:0]];
  assign w_diff    = r_abs[r_k] - r_prev[r_k];

  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_snap_count = r_snap_count;
  assign o_overrun    = r_overrun;

  // free-running period timer, held at zero while auto snapshots are off
  always_ff @(posedge clock) begin
    if (reset || !w_auto_on || w_tick) r_timer <= '0;
    else                               r_timer <= r_timer + NB_PERIOD'(1);
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state: capture, four delta steps, one done cycle
  always_comb begin
    w_next = (r_state == S_IDLE)  ? (w_trig ? S_DELTA : S_IDLE) :
             (r_state == S_DELTA) ? ((r_k == 2'd3) ? S_DONE : S_DELTA) : S_IDLE;
  end

  // state-decoded outputs
  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_snap_done = (r_state == S_DONE);
  end

  // shadow registers, shared subtractor, snapshot counter, overrun and read path
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_abs[i]  <= '0;
        r_prev[i] <= '0;
        r_dlt[i]  <= '0;
      end
      r_k          <= '0;
      r_snap_count <= '0;
      r_overrun    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_sel   <= '0;
      r_pend_high  <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) r_rd_data <= w_high ? w_reg[NB_BER-1:NB_OUT] : w_reg[NB_OUT-1:0];
      if (w_idle && w_trig) begin
        r_abs[0] <= i_samp_I;
        r_abs[1] <= i_err_I;
        r_abs[2] <= i_samp_Q;
        r_abs[3] <= i_err_Q;
        r_k      <= '0;
      end
      if (r_state == S_DELTA) begin
        r_dlt[r_k]  <= w_diff;
        r_prev[r_k] <= r_abs[r_k];
        r_k         <= r_k + 2'd1;
      end
      if (r_state == S_DONE) r_snap_count <= r_snap_count + NB_SNAPCNT'(1);
      if (w_trig && !w_idle) r_overrun <= 1'b1;
      if (i_rd_req && !w_idle) begin
        r_pend      <= 1'b1;
        r_pend_sel  <= i_rd_sel;
        r_pend_high <= i_rd_high;
      end else if (w_rd_go) r_pend <= 1'b0;
    end
  end
endmodule
